// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and unified-memory buses around mem_arbiter.
// slave is the arbiter's view; master is the datapath/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ready;
  logic                  d_req;
  logic                  d_wen;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_strb;
  logic                  d_lock;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ready;
  logic                  m_req;
  logic                  m_wen;
  logic [ADDR_W-1:0]     m_addr;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W/8-1:0]   m_strb;
  logic [DATA_W-1:0]     m_rdata;
  logic                  m_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_strb, d_lock,
           m_rdata, m_ready,
    output i_rdata, i_ready, d_rdata, d_ready,
           m_req, m_wen, m_addr, m_wdata, m_strb
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_strb, d_lock,
           m_rdata, m_ready,
    input  i_rdata, i_ready, d_rdata, d_ready,
           m_req, m_wen, m_addr, m_wdata, m_strb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data accesses:
// data has priority, fetch is protected by a starvation counter, AMOs lock the port.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);
  localparam int         STRB_W = DATA_W / 8;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, LOCKED} state_e;

  state_e              state_q, state_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;

  logic                m_req, m_wen, i_ready, d_ready;
  logic [ADDR_W-1:0]   m_addr;
  logic [DATA_W-1:0]   m_wdata;
  logic [STRB_W-1:0]   m_strb;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    m_req        = 1'b0;
    m_wen        = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_strb       = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Fetch wins only when alone or when data has used up its allowance.
        if (bus.i_req && (!bus.d_req || starve_cnt_q == LIMIT)) begin
          state_d      = SERV_I;
          starve_cnt_d = '0;
        end else if (bus.d_req) begin
          state_d = SERV_D;
          if (bus.i_req && starve_cnt_q < LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
      end
      SERV_I: begin
        m_req   = bus.i_req;
        m_addr  = bus.i_addr;
        i_ready = m_req & bus.m_ready;
        if (!bus.i_req || bus.m_ready)
          state_d = IDLE;
      end
      SERV_D, LOCKED: begin
        m_req   = bus.d_req;
        m_wen   = bus.d_wen;
        m_addr  = bus.d_addr;
        m_wdata = bus.d_wdata;
        m_strb  = bus.d_strb;
        d_ready = m_req & bus.m_ready;
        // A dropped request abandons SERV_D but never releases a lock.
        if (m_req && bus.m_ready)
          state_d = bus.d_lock ? LOCKED : IDLE;
        else if (state_q == SERV_D && !bus.d_req)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_req   = m_req;
  assign bus.m_wen   = m_wen;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;
  assign bus.m_strb  = m_strb;
  assign bus.i_ready = i_ready;
  assign bus.d_ready = d_ready;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected grants,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic nrst;
  logic busy;
  logic stray;
  int   mem_wait;
  int   wcnt;
  logic [31:0] rdata_val;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          fetch;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Memory model: ready after mem_wait cycles of a held m_req, plus a stray override.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) wcnt <= 0;
    else       wcnt <= (bus.m_req && !bus.m_ready) ? wcnt + 1 : 0;
  end
  assign bus.m_ready = stray | (bus.m_req & (wcnt == mem_wait));
  assign bus.m_rdata = rdata_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit f, input logic [31:0] a, input bit w,
                      input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rd);
    exp_t e;
    e.fetch = f; e.addr = a; e.wen = w; e.wdata = wd; e.strb = st; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // which: 0 = data, 1 = fetch, 2 = either. Returns at posedge+1 after the pulse.
  task automatic wait_ready(input int which, input int budget, output int lat);
    logic hit;
    lat = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      hit = (which == 0) ? bus.d_ready : (which == 1) ? bus.i_ready
                                       : (bus.i_ready | bus.d_ready);
      if (hit) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_ready: got no ready expected ready within %0d cycles", budget);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1 && (bus.i_ready || bus.d_ready)) begin
      chk("single_ready", {31'd0, bus.i_ready & bus.d_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: got i=%b d=%b expected none", bus.i_ready, bus.d_ready);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_kind", {31'd0, bus.i_ready}, {31'd0, mon_e.fetch});
        chk("m_addr", bus.m_addr, mon_e.addr);
        chk("m_wen", {31'd0, bus.m_wen}, {31'd0, mon_e.wen});
        if (mon_e.wen) begin
          chk("m_wdata", bus.m_wdata, mon_e.wdata);
          chk("m_strb", {28'd0, bus.m_strb}, {28'd0, mon_e.strb});
        end else if (mon_e.fetch) begin
          chk("i_rdata", bus.i_rdata, mon_e.rdata);
          chk("m_strb_fetch", {28'd0, bus.m_strb}, 32'd0);
        end else begin
          chk("d_rdata", bus.d_rdata, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int exp_cnt[10];
    exp_cnt = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    // Reset hold with both requests and a ready pending
    nrst = 1'b0; stray = 1'b1; mem_wait = 0; rdata_val = 32'h5A5A_0001;
    bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h0000_0200;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_strb = 4'hF; bus.d_lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_m_wen", {31'd0, bus.m_wen}, 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_m_strb", {28'd0, bus.m_strb}, 32'd0);
    chk("rst_readys", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, rdata_val);
    chk("rst_d_rdata", bus.d_rdata, rdata_val);

    @(posedge clk); #1;
    stray = 1'b0;
    push(1'b0, 32'h0000_0200, 1'b0, '0, '0, 32'h5A5A_0001);
    push(1'b1, 32'h0000_1000, 1'b0, '0, '0, 32'h5A5A_0001);
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_cycle1_m_req", {31'd0, bus.m_req}, 32'd0);
    @(negedge clk);
    chk("rel_cycle2_m_req", {31'd0, bus.m_req}, 32'd1);
    chk("rel_grant_data", {31'd0, bus.d_ready}, 32'd1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    wait_ready(1, 6, lat);
    chk("rel_fetch_lat", lat, 32'd2);
    bus.i_req = 1'b0;

    // Fetch with three wait states
    bus.i_addr = 32'h8000_0000; rdata_val = 32'h0000_0013; mem_wait = 3;
    push(1'b1, 32'h8000_0000, 1'b0, '0, '0, 32'h0000_0013);
    bus.i_req = 1'b1;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.m_req) chk("fetch_m_wen", {31'd0, bus.m_wen}, 32'd0);
      if (bus.i_ready) begin
        lat = n;
        break;
      end
    end
    chk("fetch_wait_lat", lat, 32'd5);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("fetch_idle_busy", {31'd0, busy}, 32'd0);
    chk("fetch_idle_m_req", {31'd0, bus.m_req}, 32'd0);

    // Priority and starvation guard, both requests held
    mem_wait = 0; rdata_val = 32'h1111_2222;
    bus.i_addr = 32'h8000_0004; bus.d_addr = 32'h0000_0300; bus.d_wen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(1'b1, 32'h8000_0004, 1'b0, '0, '0, 32'h1111_2222);
      else                  push(1'b0, 32'h0000_0300, 1'b0, '0, '0, 32'h1111_2222);
    end
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_ready(2, 6, lat);
      chk("starve_cnt", {28'd0, dut.starve_cnt_q}, exp_cnt[k]);
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;

    // AMO lock: locked read, locked write, idle gap in LOCKED, final write
    rdata_val = 32'h0000_0005;
    push(1'b0, 32'h0000_0100, 1'b0, '0, '0, 32'h0000_0005);
    push(1'b0, 32'h0000_0100, 1'b1, 32'h0000_0006, 4'hF, '0);
    push(1'b0, 32'h0000_0100, 1'b1, 32'h0000_0007, 4'h3, '0);
    push(1'b1, 32'h8000_0008, 1'b0, '0, '0, 32'h0000_0005);
    bus.i_addr = 32'h8000_0008; bus.i_req = 1'b1;
    bus.d_addr = 32'h0000_0100; bus.d_wen = 1'b0; bus.d_lock = 1'b1; bus.d_req = 1'b1;
    wait_ready(0, 6, lat);
    chk("amo_cnt_after_read", {28'd0, dut.starve_cnt_q}, 32'd1);
    bus.d_wen = 1'b1; bus.d_wdata = 32'h0000_0006; bus.d_strb = 4'hF;
    wait_ready(0, 4, lat);
    chk("amo_no_bubble_lat", lat, 32'd1);
    bus.d_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("lock_hold_busy", {31'd0, busy}, 32'd1);
      chk("lock_hold_m_req", {31'd0, bus.m_req}, 32'd0);
      chk("lock_hold_i_ready", {31'd0, bus.i_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_wdata = 32'h0000_0007; bus.d_strb = 4'h3; bus.d_lock = 1'b0;
    wait_ready(0, 4, lat);
    chk("amo_final_lat", lat, 32'd1);
    bus.d_req = 1'b0; bus.d_wen = 1'b0;
    @(negedge clk);
    chk("amo_idle_busy", {31'd0, busy}, 32'd0);
    wait_ready(1, 4, lat);
    chk("amo_fetch_lat", lat, 32'd1);
    bus.i_req = 1'b0;
    chk("amo_cnt_after_fetch", {28'd0, dut.starve_cnt_q}, 32'd0);

    // Abandoned data request, then a stray m_ready in IDLE
    mem_wait = 5; bus.d_addr = 32'h0000_0040;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    @(negedge clk);
    chk("abandon_busy", {31'd0, busy}, 32'd1);
    chk("abandon_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("abandon_d_ready", {31'd0, bus.d_ready}, 32'd0);
    @(negedge clk);
    chk("abandon_idle", {31'd0, busy}, 32'd0);
    chk("abandon_cnt", {28'd0, dut.starve_cnt_q}, 32'd1);
    @(posedge clk); #1;
    stray = 1'b1;
    @(negedge clk);
    chk("stray_readys", {30'd0, bus.i_ready, bus.d_ready}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_after_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a data access
    @(posedge clk); #1;
    bus.d_addr = 32'h0000_0080; bus.d_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_pre_m_req", {31'd0, bus.m_req}, 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("arst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("arst_cnt", {28'd0, dut.starve_cnt_q}, 32'd0);
    chk("arst_idle", {31'd0, busy}, 32'd0);

    @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
